// File: rtl/ring_counter.sv
// ring_counter: self-correcting one-hot ring sequencer
module ring_counter #(
  parameter int N        = 4,
  parameter int INIT_POS = 0,
  parameter bit DIR      = 1'b0
) (
  input  logic         clk,
  input  logic         en,
  input  logic         reset,
  output logic [N-1:0] q
);
  localparam logic [N-1:0] INIT = N'(1) << INIT_POS;
  if (N < 1 || INIT_POS < 0 || INIT_POS >= N) begin : g_bad_param
    $error("ring_counter: illegal N=%0d / INIT_POS=%0d", N, INIT_POS);
  end
  logic [N-1:0] ring_q, ring_d, rot;
  logic         legal;
  // Both rotations stay well-formed at N=1, where they reduce to the identity.
  assign rot    = DIR ? ((ring_q >> 1) | (ring_q << (N - 1)))
                      : ((ring_q << 1) | (ring_q >> (N - 1)));
  assign legal  = (ring_q != '0) && ((ring_q & (ring_q - N'(1))) == '0);
  assign ring_d = !legal ? INIT : en ? rot : ring_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) ring_q <= INIT;
    else        ring_q <= ring_d;
  assign q = ring_q;
endmodule

// File: tb/tb_ring_counter.sv
// tb_ring_counter: table, corner-case and randomized checks of ring_counter
module tb_ring_counter;
  logic       clk = 1'b0;
  logic       en = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] q4;
  logic [4:0] q5;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         pos4, pos5;

  ring_counter dut4 (.clk(clk), .en(en), .reset(reset), .q(q4));
  ring_counter #(.N(5), .INIT_POS(2), .DIR(1'b1)) dut5 (.clk(clk), .en(en), .reset(reset), .q(q5));

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] exp;
  } vec_t;

  vec_t       vecs [12];
  logic [4:0] seq5 [5];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic step(input logic e);
    en = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs = '{'{1'b1, 4'b0010}, '{1'b1, 4'b0100}, '{1'b0, 4'b0100}, '{1'b0, 4'b0100},
             '{1'b0, 4'b0100}, '{1'b0, 4'b0100}, '{1'b0, 4'b0100}, '{1'b1, 4'b1000},
             '{1'b1, 4'b0001}, '{1'b1, 4'b0010}, '{1'b1, 4'b0100}, '{1'b1, 4'b1000}};
    seq5 = '{5'b00010, 5'b00001, 5'b10000, 5'b01000, 5'b00100};

    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_init", 8'(q4), 8'b0001);
    check("reset_init_n5", 8'(q5), 8'b00100);
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      check("reset_hold", 8'(q4), 8'b0001);
    end

    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].en);
      check($sformatf("vec%0d", i), 8'(q4), 8'(vecs[i].exp));
    end

    #2 reset = 1'b0;
    #1;
    check("async_reset", 8'(q4), 8'b0001);
    check("async_reset_n5", 8'(q5), 8'b00100);
    #1 reset = 1'b1;
    step(1'b1);
    check("after_reset_adv", 8'(q4), 8'b0010);

    en = 1'b0;
    force dut4.ring_q = 4'b0000;
    #1 release dut4.ring_q;
    step(1'b0);
    check("correct_zero", 8'(q4), 8'b0001);
    force dut4.ring_q = 4'b0110;
    #1 release dut4.ring_q;
    step(1'b0);
    check("correct_multi", 8'(q4), 8'b0001);
    step(1'b1);
    check("resume_after_fix", 8'(q4), 8'b0010);

    reset = 1'b0;
    #1;
    check("n5_reset", 8'(q5), 8'b00100);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      check($sformatf("n5_seq%0d", i), 8'(q5), 8'(seq5[i]));
    end

    // Reference model tracks only the hot index and rotates it with modular arithmetic.
    reset = 1'b0;
    #1 reset = 1'b1;
    pos4 = 0;
    pos5 = 2;
    for (int i = 0; i < 400; i++) begin
      logic e;
      e = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b0;
        #1 reset = 1'b1;
        pos4 = 0;
        pos5 = 2;
      end
      step(e);
      if (e) begin
        pos4 = (pos4 + 1) % 4;
        pos5 = (pos5 + 4) % 5;
      end
      check("rand_n4", 8'(q4), 8'(1 << pos4));
      check("rand_n5", 8'(q5), 8'(1 << pos5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
